// File: rtl/gpu_cmd_bus_master.sv
// Host-side initiator for the sparkbox GPU command bus: sequences one write or
// read per request over the GPU pins and returns read data as a one-cycle response.
module gpu_cmd_bus_master #(
  parameter int CLK_DIV    = 2,
  parameter int TURNAROUND = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [7:0]  req_cmd,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        gpu_cmd_clk,
  output logic        gpu_cmd_inout,
  output logic [7:0]  gpu_cmd_o,
  output logic        gpu_cmd_oe,
  output logic [15:0] gpu_data_o,
  output logic        gpu_data_oe,
  input  logic [15:0] gpu_data_i,
  input  logic        gpu_cmd_clk_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN, S_WAIT_RD, S_RESP
  } state_e;

  localparam logic [7:0]  PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]  TURN_LAST  = 8'(TURNAROUND - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        read_q, read_d;
  logic [7:0]  phase_cnt_q, phase_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        sync1_q, sync2_q, sync_prev_q;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        strobe_rise;

  // Synchronizer and edge detector run in every state; only WAIT_RD listens.
  assign strobe_rise = sync2_q & ~sync_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      data_q      <= '0;
      read_q      <= 1'b0;
      phase_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      read_q      <= read_d;
      phase_cnt_q <= phase_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sync1_q     <= gpu_cmd_clk_out;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    read_d        = read_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    gpu_cmd_clk   = 1'b0;
    gpu_cmd_inout = 1'b0;
    gpu_cmd_o     = '0;
    gpu_cmd_oe    = 1'b0;
    gpu_data_o    = '0;
    gpu_data_oe   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cmd_d   = req_cmd;
          data_d  = req_data;
          read_d  = req_read;
          state_d = S_SETUP;
        end
      end

      S_SETUP, S_STROBE, S_HOLD: begin
        gpu_cmd_oe    = 1'b1;
        gpu_cmd_o     = cmd_q;
        gpu_cmd_inout = read_q;
        gpu_cmd_clk   = (state_q == S_STROBE);
        if (!read_q) begin
          gpu_data_oe = 1'b1;
          gpu_data_o  = data_q;
        end
        if (phase_cnt_q == PHASE_LAST) begin
          case (state_q)
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            default:  state_d = read_q ? S_TURN : S_IDLE;
          endcase
        end
      end

      S_TURN: begin
        gpu_cmd_inout = 1'b1;
        if (phase_cnt_q == TURN_LAST) state_d = S_WAIT_RD;
      end

      S_WAIT_RD: begin
        gpu_cmd_inout = 1'b1;
        // A strobe edge on the final timeout cycle still delivers data.
        if (strobe_rise) begin
          rsp_data_d = gpu_data_i;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Counters restart on every state entry and saturate rather than wrap.
    if (state_d != state_q) begin
      phase_cnt_d = '0;
      tmo_cnt_d   = '0;
    end else begin
      phase_cnt_d = (phase_cnt_q == 8'hFF)    ? phase_cnt_q : phase_cnt_q + 8'd1;
      tmo_cnt_d   = (tmo_cnt_q   == 16'hFFFF) ? tmo_cnt_q   : tmo_cnt_q + 16'd1;
    end
  end

  assign busy     = ~req_ready;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_gpu_cmd_bus_master.sv
// Randomized bench for gpu_cmd_bus_master: a transaction-level model predicts the
// pin activity and read responses cycle by cycle from the request and GPU strobe schedule.
module tb_gpu_cmd_bus_master;

  localparam int CD = 2;
  localparam int TA = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic [7:0]  req_cmd = '0;
  logic [15:0] req_data = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        gpu_cmd_clk;
  logic        gpu_cmd_inout;
  logic [7:0]  gpu_cmd_o;
  logic        gpu_cmd_oe;
  logic [15:0] gpu_data_o;
  logic        gpu_data_oe;
  logic [15:0] gpu_data_i = '0;
  logic        gpu_cmd_clk_out = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_data = '0;
  logic        last_err  = 1'b0;

  gpu_cmd_bus_master #(.CLK_DIV(CD), .TURNAROUND(TA), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_cmd(req_cmd), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .gpu_cmd_clk(gpu_cmd_clk), .gpu_cmd_inout(gpu_cmd_inout),
    .gpu_cmd_o(gpu_cmd_o), .gpu_cmd_oe(gpu_cmd_oe),
    .gpu_data_o(gpu_data_o), .gpu_data_oe(gpu_data_oe),
    .gpu_data_i(gpu_data_i), .gpu_cmd_clk_out(gpu_cmd_clk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pin snapshot layout: ready busy rsp_valid cmd_clk inout cmd_oe cmd_o[8] data_oe data_o[16]
  function automatic logic [30:0] pins();
    return {req_ready, busy, rsp_valid, gpu_cmd_clk, gpu_cmd_inout,
            gpu_cmd_oe, gpu_cmd_o, gpu_data_oe, gpu_data_o};
  endfunction

  function automatic logic [30:0] mk(input logic rdy, input logic rv, input logic cc,
                                     input logic io, input logic coe, input logic [7:0] co,
                                     input logic doe, input logic [15:0] dout);
    return {rdy, ~rdy, rv, cc, io, coe, co, doe, dout};
  endfunction

  function automatic logic [30:0] mask(input bit io_care, input bit cmd_care, input bit data_care);
    logic [30:0] m;
    m = '1;
    if (!io_care)   m[26] = 1'b0;
    if (!cmd_care)  m[24:17] = '0;
    if (!data_care) m[15:0] = '0;
    return m;
  endfunction

  task automatic check_pins(input string tag, input logic [30:0] exp, input logic [30:0] m);
    check(tag, 64'(pins() & m), 64'(exp & m));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    if (!req_ready) check("ready_wait", 64'(req_ready), 64'(1));
  endtask

  // GPU strobe level at wait-relative cycle w.
  function automatic bit line_at(input int w, input bit pre, input int drop, input int rise);
    if (w >= rise) return 1'b1;
    if (pre && w < drop) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_write(input logic [7:0] cmd, input logic [15:0] data, input bit hold);
    wait_ready();
    req_read = 1'b0; req_cmd = cmd; req_data = data; req_valid = 1'b1;
    tick();
    if (hold) begin
      req_cmd = 8'($urandom); req_data = 16'($urandom); req_read = 1'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 1; c <= 3 * CD; c++) begin
      check_pins("wr_phase", mk(1'b0, 1'b0, (c > CD && c <= 2 * CD), 1'b0, 1'b1, cmd, 1'b1, data),
                 mask(1, 1, 1));
      tick();
    end
    check_pins("wr_done", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 16'h0), mask(1, 1, 1));
    check("wr_rsp_hold", 64'({rsp_err, rsp_data}), 64'({last_err, last_data}));
    $display("[TB] WR cmd=%02h data=%04h", cmd, data);
  endtask

  task automatic do_read(input logic [7:0] cmd, input bit pre, input int drop, input int rise,
                         input logic [15:0] d, input bit hold);
    int r, ws, w;
    bit ln, err;
    logic [15:0] exp_data;
    r = TO; err = 1'b1;
    for (int k = 0; k < TO; k++) begin
      if (line_at(k - 2, pre, drop, rise) && !line_at(k - 3, pre, drop, rise)) begin
        r = k + 1; err = 1'b0;
        break;
      end
    end
    exp_data = err ? 16'h0 : d;
    ws = 3 * CD + TA + 1;
    wait_ready();
    gpu_cmd_clk_out = pre;
    req_read = 1'b1; req_cmd = cmd; req_data = 16'($urandom); req_valid = 1'b1;
    tick();
    if (hold) begin
      req_cmd = 8'($urandom); req_data = 16'($urandom); req_read = 1'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 1; c <= ws + r + 1; c++) begin
      w = c - ws;
      ln = (w < 0) ? pre : line_at(w, pre, drop, rise);
      gpu_cmd_clk_out = ln;
      gpu_data_i = ln ? d : 16'($urandom);
      if (c <= 3 * CD)
        check_pins("rd_phase", mk(1'b0, 1'b0, (c > CD && c <= 2 * CD), 1'b1, 1'b1, cmd, 1'b0, 16'h0),
                   mask(1, 1, 0));
      else if (w < 0)
        check_pins("rd_turn", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, 16'h0), mask(1, 0, 0));
      else if (w < r)
        check_pins("rd_wait", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 16'h0), mask(0, 0, 0));
      else if (w == r) begin
        check_pins("rd_resp", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 16'h0), mask(1, 0, 0));
        check("rd_data", 64'(rsp_data), 64'(exp_data));
        check("rd_err", 64'(rsp_err), 64'(err));
      end else begin
        check_pins("rd_done", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 16'h0), mask(1, 1, 1));
        check("rd_rsp_hold", 64'({rsp_err, rsp_data}), 64'({err, exp_data}));
      end
      if (c < ws + r + 1) tick();
    end
    gpu_cmd_clk_out = 1'b0;
    last_data = exp_data;
    last_err = err;
    $display("[TB] RD cmd=%02h pre=%0b rise=%0d rsp_cycle=%0d err=%0b data=%04h",
             cmd, pre, rise, r, err, exp_data);
  endtask

  initial begin
    int kind, drop, rise;
    bit hold;
    #2;
    check_pins("reset", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 16'h0), mask(1, 1, 1));
    check("reset_rsp", 64'({rsp_err, rsp_data}), 64'(0));
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    do_write(8'h12, 16'hBEEF, 0);
    do_read(8'h40, 0, 0, 10, 16'h5A5A, 0);
    do_read(8'h77, 0, 0, 1000, 16'h1111, 0);
    do_write(8'h33, 16'h0F0F, 0);
    do_read(8'h41, 1, 4, 7, 16'hC3C3, 0);
    do_read(8'h42, 0, 0, 13, 16'h2468, 0);
    do_read(8'h43, 0, 0, 14, 16'h9999, 0);

    do_write(8'hA1, 16'h1357, 1);
    do_read(8'hA2, 0, 0, 3, 16'hFACE, 1);
    do_write(8'hA3, 16'h8642, 0);

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      hold = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        do_write(8'($urandom), 16'($urandom), hold);
      end else if (kind == 1) begin
        do_read(8'($urandom), 0, 0, $urandom_range(0, 20), 16'($urandom), hold);
      end else begin
        drop = $urandom_range(0, 5);
        rise = drop + $urandom_range(1, 4);
        do_read(8'($urandom), 1, drop, rise, 16'($urandom), hold);
      end
    end
    req_valid = 1'b0;
    tick();

    // Asynchronous reset in the middle of a write strobe.
    wait_ready();
    req_read = 1'b0; req_cmd = 8'hA5; req_data = 16'h1234; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("rst_strobe_on", 64'(gpu_cmd_clk), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 64'({gpu_cmd_clk, gpu_cmd_oe, gpu_data_oe, req_ready}), 64'(4'b0001));
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_pins("rst_after", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 16'h0), mask(1, 1, 1));
    end
    check("rst_rsp_clear", 64'({rsp_err, rsp_data}), 64'(0));
    $display("[TB] RST during strobe");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
